// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - 8N1 UART receiver with 2-FF sync and 3-sample mid-bit majority vote
module uart_rx_oversample #(
   parameter int TCQ      = 1,
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       In_rx,
   output logic [7:0] Out_data,
   output logic       Out_data_vld,
   output logic       Out_frame_err,
   output logic       Out_busy
);

   localparam int BIT_CYCLES = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int HALF       = BIT_CYCLES / 2;
   localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

   localparam logic [CW-1:0] C_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] C_EARLY = CW'(HALF - 1);
   localparam logic [CW-1:0] C_MID   = CW'(HALF);
   localparam logic [CW-1:0] C_LATE  = CW'(HALF + 1);

   // Too few clocks per bit leaves no room for three distinct mid-bit samples
   if (BIT_CYCLES < 8) begin : g_bit_cycles_check
      $error("uart_rx_oversample: BIT_CYCLES must be >= 8");
   end
   if (TCQ < 0) begin : g_tcq_check
      $error("uart_rx_oversample: TCQ must be non-negative");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

   state_t        state, state_n;
   logic          s1, rx_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    data_n;
   logic          vld_n, err_n;
   logic          samp_a, samp_b;
   logic          maj, dec_pt, end_bit;

   assign maj     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
   assign dec_pt  = (cnt == C_LATE);
   assign end_bit = (cnt == C_LAST);

   // Two-stage synchroniser for the asynchronous serial pin; idles high
   always_ff @(posedge Clk) begin
      if (Rst) begin
         s1   <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         s1   <= In_rx;
         rx_s <= s1;
      end
   end

   // Capture the first two of the three mid-bit samples; the third is rx_s itself
   always_ff @(posedge Clk) begin
      if (Rst) begin
         samp_a <= 1'b1;
         samp_b <= 1'b1;
      end else begin
         if (cnt == C_EARLY) samp_a <= rx_s;
         if (cnt == C_MID)   samp_b <= rx_s;
      end
   end

   // FSM state, bit timer, shift register and registered outputs
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         Out_data      <= 8'h00;
         Out_data_vld  <= 1'b0;
         Out_frame_err <= 1'b0;
         Out_busy      <= 1'b0;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         bit_idx       <= bit_idx_n;
         shreg         <= shreg_n;
         Out_data      <= data_n;
         Out_data_vld  <= vld_n;
         Out_frame_err <= err_n;
         Out_busy      <= (state_n != IDLE);
      end
   end

   // Next-state logic: frame sequencing, decision handling and strobe generation
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      data_n    = Out_data;
      vld_n     = 1'b0;
      err_n     = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) begin
               state_n = START;
               cnt_n   = CW'(1);
            end
         end
         START: begin
            if (dec_pt && maj) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (end_bit) begin
               state_n   = DATA;
               cnt_n     = '0;
               bit_idx_n = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DATA: begin
            if (dec_pt) shreg_n = {maj, shreg[7:1]};
            if (end_bit) begin
               cnt_n = '0;
               if (bit_idx == 3'd7) state_n = STOP;
               else bit_idx_n = bit_idx + 3'd1;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         STOP: begin
            // Leave at mid-stop so a start bit immediately following is not missed
            if (dec_pt) begin
               cnt_n = '0;
               if (maj) begin
                  data_n  = shreg;
                  vld_n   = 1'b1;
                  state_n = IDLE;
               end else begin
                  err_n   = 1'b1;
                  state_n = BRK;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         BRK: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - scoreboard bench for uart_rx_oversample at 16 clocks per bit
module tb_uart_rx_oversample;

   localparam int CLK_FREQ = 1_600_000;
   localparam int BAUD     = 100_000;
   localparam int B        = 16;
   localparam int HALF     = 8;
   localparam int LAT      = 9 * B + HALF + 4;

   logic       Clk;
   logic       Rst;
   logic       In_rx;
   logic [7:0] Out_data;
   logic       Out_data_vld;
   logic       Out_frame_err;
   logic       Out_busy;

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t       sbq[$];
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         n_vld = 0;
   int         n_err = 0;
   int         exp_vld = 0;
   int         exp_err = 0;
   logic [7:0] last_good = 8'h00;

   uart_rx_oversample #(
      .TCQ      (1),
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .In_rx         (In_rx),
      .Out_data      (Out_data),
      .Out_data_vld  (Out_data_vld),
      .Out_frame_err (Out_frame_err),
      .Out_busy      (Out_busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   always @(posedge Clk) begin
      if (cyc > 60000) begin
         $display("FAIL watchdog: observed cycle=%0d limit=60000", cyc);
         $fatal(1, "watchdog expired");
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      In_rx = 1'b1;
      repeat (n) @(negedge Clk);
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) @(negedge Clk);
   endtask

   // Drive one frame; optionally invert the pin for one cycle at mid-bit of every data bit
   task automatic send(input logic [7:0] d, input logic stop_bit, input logic spike);
      logic [9:0] frame;
      exp_t       e;
      frame    = {stop_bit, d, 1'b0};
      e.cyc    = cyc + LAT;
      e.is_err = !stop_bit;
      if (stop_bit) begin
         e.data    = d;
         last_good = d;
         exp_vld++;
      end else begin
         e.data = last_good;
         exp_err++;
      end
      sbq.push_back(e);
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < B; j++) begin
            if (spike && i >= 1 && i <= 8 && j == HALF) In_rx = ~frame[i];
            else In_rx = frame[i];
            @(negedge Clk);
         end
      end
   endtask

   // Drive a frame but pulse reset partway into frame bit abort_i, then release the line
   task automatic send_abort(input logic [7:0] d, input int abort_i);
      logic [9:0] frame;
      frame = {1'b1, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int j = 0; j < B; j++) begin
            if (i == abort_i && j == 4) begin
               Rst = 1'b1;
               @(negedge Clk);
               Rst   = 1'b0;
               In_rx = 1'b1;
               last_good = 8'h00;
               check("abort_data", Out_data, 8'h00);
               check("abort_vld", Out_data_vld, 1'b0);
               check("abort_err", Out_frame_err, 1'b0);
               check("abort_busy", Out_busy, 1'b0);
               return;
            end
            In_rx = frame[i];
            @(negedge Clk);
         end
      end
   endtask

   // Scoreboard: every strobe must match the oldest expected frame outcome
   always @(negedge Clk) begin : mon
      exp_t e;
      if (Out_data_vld || Out_frame_err) begin
         check("strobe_expected", sbq.size() > 0, 1'b1);
         check("vld_err_exclusive", Out_data_vld & Out_frame_err, 1'b0);
         if (Out_data_vld) n_vld++;
         if (Out_frame_err) n_err++;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("strobe_kind_err", Out_frame_err, e.is_err);
            check("strobe_data", Out_data, e.data);
            check("strobe_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin : stim
      int start;
      In_rx = 1'b1;
      Rst   = 1'b1;
      repeat (3) @(negedge Clk);
      check("reset_data", Out_data, 8'h00);
      check("reset_vld", Out_data_vld, 1'b0);
      check("reset_err", Out_frame_err, 1'b0);
      check("reset_busy", Out_busy, 1'b0);
      Rst = 1'b0;
      idle(8);

      // Single good frame
      send(8'hA5, 1'b1, 1'b0);
      idle(20);
      check("hold_data_a5", Out_data, 8'hA5);

      // Start-bit glitch of three cycles
      start = cyc;
      In_rx = 1'b0;
      repeat (3) @(negedge Clk);
      In_rx = 1'b1;
      wait_to(start + 5);
      check("glitch_busy_high", Out_busy, 1'b1);
      wait_to(start + 11);
      check("glitch_busy_before_drop", Out_busy, 1'b1);
      wait_to(start + 12);
      check("glitch_busy_low", Out_busy, 1'b0);
      idle(20);

      // Bad stop bit with held-low line, then a good 0x00 frame
      send(8'h3C, 1'b0, 1'b0);
      In_rx = 1'b0;
      repeat (40) @(negedge Clk);
      check("break_busy", Out_busy, 1'b1);
      idle(20);
      check("after_break_busy", Out_busy, 1'b0);
      send(8'h00, 1'b1, 1'b0);
      idle(20);

      // Back-to-back frames with no idle gap
      send(8'h55, 1'b1, 1'b0);
      send(8'hAA, 1'b1, 1'b0);
      idle(20);

      // Mid-bit spikes rejected by majority vote
      send(8'h0F, 1'b1, 1'b1);
      idle(20);

      // Reset during data bit 4 aborts the frame; the next frame must still decode
      send_abort(8'hC3, 5);
      idle(20);
      send(8'h81, 1'b1, 1'b0);
      idle(30);

      check("scoreboard_drained", sbq.size(), 0);
      check("vld_count", n_vld, exp_vld);
      check("err_count", n_err, exp_err);
      check("final_data", Out_data, 8'h81);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
